// File: rtl/decode_execute_pipeline_register_pkg.sv
// Shared definitions for the pipeline boundary registers.
// The control bundle is reused by the later execute/memory and
// memory/writeback registers, so its field order must not change.
package decode_execute_pipeline_register_pkg;

  localparam logic [3:0] PC_REGISTER       = 4'd15;
  localparam int         REG_ADDRESS_WIDTH = 4;
  localparam int         ALU_CONTROL_WIDTH = 2;
  localparam int         FLAG_WRITE_WIDTH  = 2;
  localparam int         CONDITION_WIDTH   = 4;

  typedef struct packed {
    logic                         reg_write;
    logic                         mem_write;
    logic                         mem_to_reg;
    logic                         alu_src;
    logic                         branch;
    logic [ALU_CONTROL_WIDTH-1:0] alu_control;
    logic [FLAG_WRITE_WIDTH-1:0]  flag_write;
    logic [CONDITION_WIDTH-1:0]   condition;
  } control_bundle_t;

  // An all-zero bundle writes nothing and never branches, so it is a safe bubble.
  localparam control_bundle_t CONTROL_BUBBLE = '0;

  // True when the writeback in flight targets this source register.
  // R15 is served by the PC path and is never forwarded here.
  function automatic logic bypass_match(
    input logic                         wb_write_enable,
    input logic [REG_ADDRESS_WIDTH-1:0] wb_write_address,
    input logic [REG_ADDRESS_WIDTH-1:0] read_address
  );
    return wb_write_enable
        && (wb_write_address == read_address)
        && (read_address != PC_REGISTER);
  endfunction

endpackage

// File: rtl/decode_execute_pipeline_register_operand_capture_slot.sv
// One read-port slot of the decode/execute register: the source address and
// the operand value, with a writeback bypass that also keeps a stalled
// operand fresh while the instruction waits in this stage.
module operand_capture_slot
  import decode_execute_pipeline_register_pkg::*;
#(
  parameter int W = 32
) (
  input  logic                         clk,
  input  logic                         reset_asynchronous,
  input  logic                         stall,
  input  logic                         flush,
  input  logic [REG_ADDRESS_WIDTH-1:0] inp_read_address,
  input  logic [W-1:0]                 inp_read_data,
  input  logic                         inp_wb_write_enable,
  input  logic [REG_ADDRESS_WIDTH-1:0] inp_wb_write_address,
  input  logic [W-1:0]                 inp_wb_write_data,
  output logic [REG_ADDRESS_WIDTH-1:0] out_read_address,
  output logic [W-1:0]                 out_read_data
);

  logic [REG_ADDRESS_WIDTH-1:0] compare_address;
  logic                         bypass_hit;
  logic [W-1:0]                 load_data;

  // While stalled the held address is the one that matters; otherwise the incoming one.
  always_comb begin
    compare_address = stall ? out_read_address : inp_read_address;
    bypass_hit      = bypass_match(inp_wb_write_enable, inp_wb_write_address, compare_address);
    load_data       = bypass_hit ? inp_wb_write_data : inp_read_data;
  end

  // Flush clears, stall holds but still accepts a matching writeback, otherwise load.
  always_ff @(posedge clk or posedge reset_asynchronous) begin
    if (reset_asynchronous) begin
      out_read_address <= '0;
      out_read_data    <= '0;
    end else if (flush) begin
      out_read_address <= '0;
      out_read_data    <= '0;
    end else if (stall) begin
      if (bypass_hit) begin
        out_read_data <= inp_wb_write_data;
      end
    end else begin
      out_read_address <= inp_read_address;
      out_read_data    <= load_data;
    end
  end

endmodule

// File: rtl/decode_execute_pipeline_register.sv
// Decode/execute pipeline boundary. Operands go through two capture slots
// that carry the writeback bypass; the immediate, destination, control bundle
// and valid bit are plain load/hold/flush registers kept here.
module decode_execute_pipeline_register
  import decode_execute_pipeline_register_pkg::*;
#(
  parameter int W = 32
) (
  input  logic                         clk,
  input  logic                         reset_asynchronous,
  input  logic                         stall,
  input  logic                         flush,
  input  logic [3:0]                   inp_read_address0,
  input  logic [3:0]                   inp_read_address1,
  input  logic [W-1:0]                 inp_read_data0,
  input  logic [W-1:0]                 inp_read_data1,
  input  logic [3:0]                   inp_write_address,
  input  logic [W-1:0]                 inp_extended_immediate,
  input  logic                         inp_reg_write,
  input  logic                         inp_mem_write,
  input  logic                         inp_mem_to_reg,
  input  logic                         inp_alu_src,
  input  logic                         inp_branch,
  input  logic [ALU_CONTROL_WIDTH-1:0] inp_alu_control,
  input  logic [FLAG_WRITE_WIDTH-1:0]  inp_flag_write,
  input  logic [CONDITION_WIDTH-1:0]   inp_condition,
  input  logic                         inp_wb_write_enable,
  input  logic [3:0]                   inp_wb_write_address,
  input  logic [W-1:0]                 inp_wb_write_data,
  output logic [3:0]                   out_read_address0,
  output logic [3:0]                   out_read_address1,
  output logic [W-1:0]                 out_read_data0,
  output logic [W-1:0]                 out_read_data1,
  output logic [3:0]                   out_write_address,
  output logic [W-1:0]                 out_extended_immediate,
  output logic                         out_reg_write,
  output logic                         out_mem_write,
  output logic                         out_mem_to_reg,
  output logic                         out_alu_src,
  output logic                         out_branch,
  output logic [ALU_CONTROL_WIDTH-1:0] out_alu_control,
  output logic [FLAG_WRITE_WIDTH-1:0]  out_flag_write,
  output logic [CONDITION_WIDTH-1:0]   out_condition,
  output logic                         out_valid
);

  control_bundle_t control_in;
  control_bundle_t control_q;

  operand_capture_slot #(.W(W)) slot0 (
    .clk                  (clk),
    .reset_asynchronous   (reset_asynchronous),
    .stall                (stall),
    .flush                (flush),
    .inp_read_address     (inp_read_address0),
    .inp_read_data        (inp_read_data0),
    .inp_wb_write_enable  (inp_wb_write_enable),
    .inp_wb_write_address (inp_wb_write_address),
    .inp_wb_write_data    (inp_wb_write_data),
    .out_read_address     (out_read_address0),
    .out_read_data        (out_read_data0)
  );

  operand_capture_slot #(.W(W)) slot1 (
    .clk                  (clk),
    .reset_asynchronous   (reset_asynchronous),
    .stall                (stall),
    .flush                (flush),
    .inp_read_address     (inp_read_address1),
    .inp_read_data        (inp_read_data1),
    .inp_wb_write_enable  (inp_wb_write_enable),
    .inp_wb_write_address (inp_wb_write_address),
    .inp_wb_write_data    (inp_wb_write_data),
    .out_read_address     (out_read_address1),
    .out_read_data        (out_read_data1)
  );

  // Gather the individual decoded control inputs into the shared bundle.
  always_comb begin
    control_in             = CONTROL_BUBBLE;
    control_in.reg_write   = inp_reg_write;
    control_in.mem_write   = inp_mem_write;
    control_in.mem_to_reg  = inp_mem_to_reg;
    control_in.alu_src     = inp_alu_src;
    control_in.branch      = inp_branch;
    control_in.alu_control = inp_alu_control;
    control_in.flag_write  = inp_flag_write;
    control_in.condition   = inp_condition;
  end

  // Non-operand state: a flush bubble must clear every write enable and the valid bit.
  always_ff @(posedge clk or posedge reset_asynchronous) begin
    if (reset_asynchronous) begin
      out_write_address      <= '0;
      out_extended_immediate <= '0;
      control_q              <= CONTROL_BUBBLE;
      out_valid              <= 1'b0;
    end else if (flush) begin
      out_write_address      <= '0;
      out_extended_immediate <= '0;
      control_q              <= CONTROL_BUBBLE;
      out_valid              <= 1'b0;
    end else if (!stall) begin
      out_write_address      <= inp_write_address;
      out_extended_immediate <= inp_extended_immediate;
      control_q              <= control_in;
      out_valid              <= 1'b1;
    end
  end

  assign out_reg_write   = control_q.reg_write;
  assign out_mem_write   = control_q.mem_write;
  assign out_mem_to_reg  = control_q.mem_to_reg;
  assign out_alu_src     = control_q.alu_src;
  assign out_branch      = control_q.branch;
  assign out_alu_control = control_q.alu_control;
  assign out_flag_write  = control_q.flag_write;
  assign out_condition   = control_q.condition;

endmodule

// File: tb/tb_decode_execute_pipeline_register.sv
// Randomized bench for the decode/execute register, checked against a
// cycle-level behavioural model of load, stall-refresh, flush and reset.
module tb_decode_execute_pipeline_register;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset_asynchronous;
  logic         stall, flush;
  logic [3:0]   inp_read_address0, inp_read_address1, inp_write_address;
  logic [W-1:0] inp_read_data0, inp_read_data1, inp_extended_immediate;
  logic         inp_reg_write, inp_mem_write, inp_mem_to_reg, inp_alu_src, inp_branch;
  logic [1:0]   inp_alu_control, inp_flag_write;
  logic [3:0]   inp_condition;
  logic         inp_wb_write_enable;
  logic [3:0]   inp_wb_write_address;
  logic [W-1:0] inp_wb_write_data;

  logic [3:0]   out_read_address0, out_read_address1, out_write_address;
  logic [W-1:0] out_read_data0, out_read_data1, out_extended_immediate;
  logic         out_reg_write, out_mem_write, out_mem_to_reg, out_alu_src, out_branch;
  logic [1:0]   out_alu_control, out_flag_write;
  logic [3:0]   out_condition;
  logic         out_valid;

  // Reference model state: what the stage should hold after the next edge.
  logic [3:0]   m_addr0, m_addr1, m_wa;
  logic [W-1:0] m_data0, m_data1, m_imm;
  logic [12:0]  m_ctrl;
  logic         m_valid;

  int check_count = 0;
  int error_count = 0;

  always #5 clk = ~clk;

  decode_execute_pipeline_register #(.W(W)) dut (
    .clk                    (clk),
    .reset_asynchronous     (reset_asynchronous),
    .stall                  (stall),
    .flush                  (flush),
    .inp_read_address0      (inp_read_address0),
    .inp_read_address1      (inp_read_address1),
    .inp_read_data0         (inp_read_data0),
    .inp_read_data1         (inp_read_data1),
    .inp_write_address      (inp_write_address),
    .inp_extended_immediate (inp_extended_immediate),
    .inp_reg_write          (inp_reg_write),
    .inp_mem_write          (inp_mem_write),
    .inp_mem_to_reg         (inp_mem_to_reg),
    .inp_alu_src            (inp_alu_src),
    .inp_branch             (inp_branch),
    .inp_alu_control        (inp_alu_control),
    .inp_flag_write         (inp_flag_write),
    .inp_condition          (inp_condition),
    .inp_wb_write_enable    (inp_wb_write_enable),
    .inp_wb_write_address   (inp_wb_write_address),
    .inp_wb_write_data      (inp_wb_write_data),
    .out_read_address0      (out_read_address0),
    .out_read_address1      (out_read_address1),
    .out_read_data0         (out_read_data0),
    .out_read_data1         (out_read_data1),
    .out_write_address      (out_write_address),
    .out_extended_immediate (out_extended_immediate),
    .out_reg_write          (out_reg_write),
    .out_mem_write          (out_mem_write),
    .out_mem_to_reg         (out_mem_to_reg),
    .out_alu_src            (out_alu_src),
    .out_branch             (out_branch),
    .out_alu_control        (out_alu_control),
    .out_flag_write         (out_flag_write),
    .out_condition          (out_condition),
    .out_valid              (out_valid)
  );

  // Count one comparison and report it if the observed value is wrong.
  task automatic checkOutput(input string tag, input logic [W-1:0] observed, input logic [W-1:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Writeback forwarding rule: enabled, same register, and not R15.
  function automatic logic wbHits(input logic [3:0] address);
    return inp_wb_write_enable && (inp_wb_write_address == address) && (address != 4'd15);
  endfunction

  task automatic modelReset();
    m_addr0 = '0; m_addr1 = '0; m_wa = '0;
    m_data0 = '0; m_data1 = '0; m_imm = '0;
    m_ctrl = '0;  m_valid = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic modelStep();
    if (flush) begin
      modelReset();
    end else if (stall) begin
      if (wbHits(m_addr0)) m_data0 = inp_wb_write_data;
      if (wbHits(m_addr1)) m_data1 = inp_wb_write_data;
    end else begin
      m_data0 = wbHits(inp_read_address0) ? inp_wb_write_data : inp_read_data0;
      m_data1 = wbHits(inp_read_address1) ? inp_wb_write_data : inp_read_data1;
      m_addr0 = inp_read_address0;
      m_addr1 = inp_read_address1;
      m_wa    = inp_write_address;
      m_imm   = inp_extended_immediate;
      m_ctrl  = {inp_reg_write, inp_mem_write, inp_mem_to_reg, inp_alu_src, inp_branch,
                 inp_alu_control, inp_flag_write, inp_condition};
      m_valid = 1'b1;
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".addr0"}, W'(out_read_address0), W'(m_addr0));
    checkOutput({tag, ".addr1"}, W'(out_read_address1), W'(m_addr1));
    checkOutput({tag, ".data0"}, out_read_data0, m_data0);
    checkOutput({tag, ".data1"}, out_read_data1, m_data1);
    checkOutput({tag, ".waddr"}, W'(out_write_address), W'(m_wa));
    checkOutput({tag, ".imm"},   out_extended_immediate, m_imm);
    checkOutput({tag, ".ctrl"},
                W'({out_reg_write, out_mem_write, out_mem_to_reg, out_alu_src, out_branch,
                    out_alu_control, out_flag_write, out_condition}), W'(m_ctrl));
    checkOutput({tag, ".valid"}, W'(out_valid), W'(m_valid));
  endtask

  // Inputs must already be driven (after a falling edge); step model, clock, check.
  task automatic applyStimulus(input string tag);
    modelStep();
    @(posedge clk);
    #1;
    checkAll(tag);
  endtask

  task automatic randomizeInputs(input bit allow_control);
    inp_read_address0      = 4'($urandom);
    inp_read_address1      = ($urandom_range(0, 3) == 0) ? inp_read_address0 : 4'($urandom);
    inp_read_data0         = $urandom;
    inp_read_data1         = $urandom;
    inp_write_address      = 4'($urandom);
    inp_extended_immediate = $urandom;
    {inp_reg_write, inp_mem_write, inp_mem_to_reg, inp_alu_src, inp_branch} = 5'($urandom);
    inp_alu_control        = 2'($urandom);
    inp_flag_write         = 2'($urandom);
    inp_condition          = 4'($urandom);
    inp_wb_write_enable    = 1'($urandom);
    inp_wb_write_data      = $urandom;
    case ($urandom_range(0, 3))
      0:       inp_wb_write_address = inp_read_address0;
      1:       inp_wb_write_address = inp_read_address1;
      2:       inp_wb_write_address = stall ? m_addr1 : 4'd15;
      default: inp_wb_write_address = 4'($urandom);
    endcase
    if (allow_control) begin
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 9) == 0);
      if (stall && $urandom_range(0, 1) == 1) inp_wb_write_address = m_addr0;
    end
  endtask

  task automatic idleInputs();
    stall = 1'b0; flush = 1'b0;
    inp_read_address0 = '0; inp_read_address1 = '0; inp_write_address = '0;
    inp_read_data0 = '0; inp_read_data1 = '0; inp_extended_immediate = '0;
    {inp_reg_write, inp_mem_write, inp_mem_to_reg, inp_alu_src, inp_branch} = '0;
    inp_alu_control = '0; inp_flag_write = '0; inp_condition = '0;
    inp_wb_write_enable = 1'b0; inp_wb_write_address = '0; inp_wb_write_data = '0;
  endtask

  initial begin
    reset_asynchronous = 1'b1;
    idleInputs();
    modelReset();
    #1;
    checkAll("reset_initial");

    // Load something nonzero, then assert reset mid-cycle and expect immediate zeros.
    @(negedge clk);
    reset_asynchronous = 1'b0;
    randomizeInputs(1'b0);
    inp_reg_write = 1'b1;
    applyStimulus("reset_preload");
    #2;
    reset_asynchronous = 1'b1;
    modelReset();
    #1;
    checkAll("reset_async");
    @(posedge clk);
    #1;
    checkAll("reset_held");
    @(negedge clk);
    reset_asynchronous = 1'b0;
    stall = 1'b1;
    inp_wb_write_enable = 1'b0;
    applyStimulus("reset_release_stalled");

    // Plain load with writeback idle.
    @(negedge clk);
    idleInputs();
    inp_read_address0 = 4'd3; inp_read_data0 = 32'h11;
    inp_read_address1 = 4'd4; inp_read_data1 = 32'h22;
    applyStimulus("plain_load");
    checkOutput("plain_load.data0_const", out_read_data0, 32'h11);
    checkOutput("plain_load.data1_const", out_read_data1, 32'h22);
    checkOutput("plain_load.valid_const", W'(out_valid), 32'd1);

    // Same-cycle bypass, then R15 which must not be bypassed.
    @(negedge clk);
    inp_read_address0 = 4'd5; inp_read_data0 = 32'hAAAA;
    inp_wb_write_enable = 1'b1; inp_wb_write_address = 4'd5; inp_wb_write_data = 32'h1234;
    applyStimulus("bypass");
    checkOutput("bypass.data0_const", out_read_data0, 32'h1234);
    @(negedge clk);
    inp_read_address1 = 4'd15; inp_read_data1 = 32'hCAFE;
    inp_wb_write_address = 4'd15; inp_wb_write_data = 32'h9999;
    applyStimulus("bypass_r15");
    checkOutput("bypass_r15.data1_const", out_read_data1, 32'hCAFE);

    // Stall refresh: hold addr1=7 for three edges, writeback hits on the second.
    @(negedge clk);
    idleInputs();
    inp_read_address1 = 4'd7; inp_read_data1 = 32'h0; inp_reg_write = 1'b1;
    applyStimulus("stall_load");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      randomizeInputs(1'b0);
      stall = 1'b1; flush = 1'b0;
      inp_wb_write_enable  = (i == 1);
      inp_wb_write_address = 4'd7;
      inp_wb_write_data    = 32'h55;
      applyStimulus("stall_refresh");
      checkOutput("stall_refresh.data1_const", out_read_data1, (i == 0) ? 32'h0 : 32'h55);
    end

    // Flush has priority over stall.
    @(negedge clk);
    stall = 1'b1; flush = 1'b1;
    inp_reg_write = 1'b1; inp_mem_write = 1'b1;
    applyStimulus("flush_priority");
    checkOutput("flush_priority.valid_const", W'(out_valid), 32'd0);

    // Both operands read the same register that is being written.
    @(negedge clk);
    idleInputs();
    inp_read_address0 = 4'd2; inp_read_address1 = 4'd2;
    inp_read_data0 = 32'h1; inp_read_data1 = 32'h2;
    inp_wb_write_enable = 1'b1; inp_wb_write_address = 4'd2; inp_wb_write_data = 32'hBEEF;
    applyStimulus("dual_match");

    // Randomized traffic mixing load, stall, flush and writeback.
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      randomizeInputs(1'b1);
      applyStimulus("random");
    end

    // Reset during a stall discards the held instruction.
    @(negedge clk);
    idleInputs();
    inp_read_address0 = 4'd9; inp_read_data0 = 32'h77; inp_branch = 1'b1;
    applyStimulus("stall_reset_load");
    @(negedge clk);
    stall = 1'b1;
    #2;
    reset_asynchronous = 1'b1;
    modelReset();
    #1;
    checkAll("stall_reset");

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule

// File: doc/decode_execute_pipeline_register.md
# decode_execute_pipeline_register

Pipeline boundary between decode and execute in the pipelined processor. It captures the two `register_file` read operands, their source addresses, the extended immediate and the decoded control bundle on each clock edge. A writeback bypass corrects operands that the register file returns stale because the write and the read fall in the same cycle. Stall holds the stage and keeps refreshing held operands; flush inserts a bubble.

## Interface
Parameters
- `W`, 32, datapath width; must match `register_file`.

Ports
- `clk`  in  1  rising-edge clock.
- `reset_asynchronous`  in  1  asynchronous, active-high reset.
- `stall`  in  1  hold all outputs; operand refresh still applies.
- `flush`  in  1  load a bubble; priority over `stall`.
- `inp_read_address0`, `inp_read_address1`  in  4  source register numbers presented to the register file.
- `inp_read_data0`, `inp_read_data1`  in  W  register file read data.
- `inp_write_address`  in  4  destination register.
- `inp_extended_immediate`  in  W  extended immediate.
- `inp_reg_write`, `inp_mem_write`, `inp_mem_to_reg`, `inp_alu_src`, `inp_branch`  in  1 each  decoded controls.
- `inp_alu_control`  in  2  ALU operation.
- `inp_flag_write`  in  2  flag-update enables.
- `inp_condition`  in  4  condition field.
- `inp_wb_write_enable`  in  1  writeback write strobe, the same one driving `register_file`.
- `inp_wb_write_address`  in  4  writeback destination.
- `inp_wb_write_data`  in  W  writeback data.
- `out_*`  out  same widths  registered copy of every `inp_*` decode input above: addresses, data, immediate, controls.
- `out_valid`  out  1  stage holds a real instruction.

## Operation
- `match_k = inp_wb_write_enable & (inp_wb_write_address == addr_k) & (addr_k != 15)`.
  - `addr_k` is the incoming address in the load case and the held `out_read_address_k` in the stall case.
- R15 is never bypassed; its value comes from the dedicated PC path.
- **Load** (no flush, no stall): every output takes its input.
  - Operand k takes `inp_wb_write_data` if `match_k` is true, else `inp_read_data_k`.
  - `out_valid` becomes 1.
- **Stall** (`stall=1`, `flush=0`): every output holds its value.
  - Exception: held operand k takes `inp_wb_write_data` if `match_k` is true for the held address.
- **Flush** (`flush=1`, regardless of `stall`): all outputs are cleared to 0, including `out_valid`, `out_reg_write`, `out_mem_write`, `out_branch` and `out_flag_write`.
  - Result: a bubble that changes no architectural state.
- Both operands are evaluated independently; if both match, both take the writeback data.

## Timing
- Latency: 1 cycle. Input at edge n appears at the outputs after edge n.
- Reset: asserting `reset_asynchronous` forces every output to 0 immediately, without waiting for a clock edge.
  - Outputs stay 0 while reset is asserted.
  - The first load occurs on the first rising edge after deassertion.
  - Reset asserted during a stall discards the held instruction.
- Bypass select is combinational from same-cycle inputs; no extra cycle.
- A stall lasting N cycles holds the same instruction for N edges. The refresh can fire on any of those edges; the last matching write wins.
- No handshake beyond `stall`/`flush`. Both are sampled at the rising edge.

## Structure
- Shared package contents:
  - `PC_REGISTER = 4'd15`;
  - `ALU_CONTROL_WIDTH = 2`, `FLAG_WRITE_WIDTH = 2`, `CONDITION_WIDTH = 4`;
  - a packed control-bundle typedef reused by the execute/memory and memory/writeback registers.
- Sub-module `operand_capture_slot #(W)`: one address register and one data register, with async reset, load/hold/flush, and bypass compare. It is instantiated twice, once per read port.
- The top level holds the immediate, destination and control registers plus `out_valid`.

## Test plan
- **Reset:** drive all inputs nonzero and assert reset mid-cycle. All outputs read 0 before the next edge, and `out_valid=0` on the first edge after deassertion until a load.
- **Plain load:** addr0=3, data0=0x11, addr1=4, data1=0x22, writeback idle → after one edge the outputs are 0x11/0x22 and `out_valid=1`.
- **Same-cycle bypass:** addr0=5, data0=0xAAAA, writeback writes 5 with 0x1234 → `out_read_data0=0x1234`.
  - Repeat with addr1=15 and a writeback to address 15: `out_read_data1` equals `inp_read_data1`.
- **Stall refresh:** load addr1=7 with data 0x0, then stall 3 cycles, writing 7 with 0x55 in the second cycle → the data holds 0x0 then becomes 0x55. All other outputs stay unchanged.
- **Flush priority:** `stall=1`, `flush=1` with `reg_write=1`, `mem_write=1` → after the edge all controls are 0 and `out_valid=0`.
- **Dual match:** addr0=addr1=2, writeback writes 2 with 0xBEEF → both operands read 0xBEEF.
